// File: rtl/dmem_responder.sv
// Data-memory responder: serves core load/store requests over a req/ack bus,
// stalling the core until each access completes. Optional posted writes: DMEM_WRITE_BUFFER_EN.
module dmem_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_err
);

    // state | meaning
    // IDLE  | waiting for a core request; latches address/data/direction
    // REQ   | bus_req held, waiting for bus_ack or timeout
    // DONE  | result available, core released for one cycle
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic       req_present;
    logic       timeout;

`ifdef DMEM_WRITE_BUFFER_EN
    logic       posted;
`endif

    assign req_present = mem_ren | mem_wen;
    assign timeout     = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_present) state_nxt = REQ;
            REQ:     if (bus_ack || timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ack takes precedence over a timeout landing in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt       <= '0;
            mem_din   <= '0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_err   <= 1'b0;
`ifdef DMEM_WRITE_BUFFER_EN
            posted    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req_present) begin
                        bus_addr  <= mem_addr & 32'hFFFF_FFFC;
                        bus_wdata <= mem_dout;
                        bus_we    <= mem_wen;
`ifdef DMEM_WRITE_BUFFER_EN
                        posted    <= mem_wen;
`endif
                    end
                end
                REQ: begin
                    cnt <= cnt + 8'd1;
                    if (bus_ack) begin
                        if (!bus_we) mem_din <= bus_rdata;
                    end else if (timeout) begin
                        if (!bus_we) mem_din <= ERR_DATA;
                        bus_err <= 1'b1;
                    end
                end
                DONE: begin
`ifdef DMEM_WRITE_BUFFER_EN
                    posted <= 1'b0;
`endif
                end
                default: cnt <= '0;
            endcase
        end
    end

    // While a posted write drains, only a newly arriving request is stalled;
    // it is held through DONE and then served from IDLE.
    always_comb begin
        mem_stall = 1'b0;
        bus_req   = 1'b0;
        case (state)
            IDLE: begin
`ifdef DMEM_WRITE_BUFFER_EN
                mem_stall = mem_ren & ~mem_wen;
`else
                mem_stall = req_present;
`endif
            end
            REQ: begin
                bus_req = 1'b1;
`ifdef DMEM_WRITE_BUFFER_EN
                mem_stall = posted ? req_present : 1'b1;
`else
                mem_stall = 1'b1;
`endif
            end
            DONE: begin
`ifdef DMEM_WRITE_BUFFER_EN
                mem_stall = posted & req_present;
`else
                mem_stall = 1'b0;
`endif
            end
            default: mem_stall = 1'b0;
        endcase
        if (!rst) mem_stall = 1'b0;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (TIMEOUT_CYCLES = 4).
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_ren = 1'b0;
    logic        mem_wen = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_dout = '0;
    logic [31:0] mem_din;
    logic        mem_stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;
    logic        bus_err;

    int npass = 0;
    int nchk  = 0;

    always #5 clk = ~clk;

    dmem_responder #(.TIMEOUT_CYCLES(4), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .rst(rst), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
        .mem_stall(mem_stall), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_ack(bus_ack), .bus_err(bus_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        mem_ren = 1'b1;
        tick();
        tick();
        #1;
        nchk++; if (mem_stall !== 1'b0) $display("FAIL rst_stall got=%b exp=0", mem_stall); else npass++;
        nchk++; if (bus_req !== 1'b0) $display("FAIL rst_req got=%b exp=0", bus_req); else npass++;
        nchk++; if (mem_din !== 32'h0) $display("FAIL rst_din got=%h exp=0", mem_din); else npass++;
        nchk++; if (bus_err !== 1'b0) $display("FAIL rst_err got=%b exp=0", bus_err); else npass++;
        nchk++; if (bus_addr !== 32'h0) $display("FAIL rst_addr got=%h exp=0", bus_addr); else npass++;
        rst = 1'b1;
        mem_ren = 1'b0;
        tick();
    endtask

    task automatic test_read();
        mem_ren = 1'b1;
        mem_addr = 32'h0000_0104;
        #1;
        nchk++; if (mem_stall !== 1'b1) $display("FAIL rd_stall_t got=%b exp=1", mem_stall); else npass++;
        nchk++; if (bus_req !== 1'b0) $display("FAIL rd_req_t got=%b exp=0", bus_req); else npass++;
        tick();
        nchk++; if (bus_req !== 1'b1) $display("FAIL rd_req_t1 got=%b exp=1", bus_req); else npass++;
        nchk++; if (bus_addr !== 32'h104) $display("FAIL rd_addr got=%h exp=104", bus_addr); else npass++;
        nchk++; if (bus_we !== 1'b0) $display("FAIL rd_we got=%b exp=0", bus_we); else npass++;
        nchk++; if (mem_stall !== 1'b1) $display("FAIL rd_stall_t1 got=%b exp=1", mem_stall); else npass++;
        bus_ack = 1'b1;
        bus_rdata = 32'h1234_5678;
        tick();
        bus_ack = 1'b0;
        #1;
        nchk++; if (mem_stall !== 1'b0) $display("FAIL rd_stall_done got=%b exp=0", mem_stall); else npass++;
        nchk++; if (bus_req !== 1'b0) $display("FAIL rd_req_done got=%b exp=0", bus_req); else npass++;
        nchk++; if (mem_din !== 32'h1234_5678) $display("FAIL rd_din got=%h exp=12345678", mem_din); else npass++;
        mem_ren = 1'b0;
        tick();
    endtask

    task automatic test_write();
        mem_wen = 1'b1;
        mem_addr = 32'h0000_0203;
        mem_dout = 32'hA5A5_0001;
        #1;
        nchk++; if (mem_stall !== 1'b1) $display("FAIL wr_stall_t got=%b exp=1", mem_stall); else npass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            nchk++; if (bus_req !== 1'b1) $display("FAIL wr_req c%0d got=%b exp=1", i, bus_req); else npass++;
            nchk++; if (bus_we !== 1'b1) $display("FAIL wr_we c%0d got=%b exp=1", i, bus_we); else npass++;
            nchk++; if (bus_addr !== 32'h200) $display("FAIL wr_addr c%0d got=%h exp=200", i, bus_addr); else npass++;
            nchk++; if (bus_wdata !== 32'hA5A5_0001) $display("FAIL wr_wdata c%0d got=%h exp=a5a50001", i, bus_wdata); else npass++;
            nchk++; if (mem_stall !== 1'b1) $display("FAIL wr_stall c%0d got=%b exp=1", i, mem_stall); else npass++;
            mem_addr = 32'hFFFF_FFFF;
            mem_dout = 32'h0;
            if (i == 2) bus_ack = 1'b1;
        end
        tick();
        bus_ack = 1'b0;
        #1;
        nchk++; if (mem_stall !== 1'b0) $display("FAIL wr_stall_done got=%b exp=0", mem_stall); else npass++;
        nchk++; if (bus_req !== 1'b0) $display("FAIL wr_req_done got=%b exp=0", bus_req); else npass++;
        nchk++; if (mem_din !== 32'h1234_5678) $display("FAIL wr_din_kept got=%h exp=12345678", mem_din); else npass++;
        mem_wen = 1'b0;
        tick();
    endtask

    task automatic test_simul();
        mem_ren = 1'b1;
        mem_wen = 1'b1;
        mem_addr = 32'h0000_0300;
        mem_dout = 32'h1111_2222;
        tick();
        nchk++; if (bus_we !== 1'b1) $display("FAIL sim_we got=%b exp=1", bus_we); else npass++;
        nchk++; if (bus_wdata !== 32'h1111_2222) $display("FAIL sim_wdata got=%h exp=11112222", bus_wdata); else npass++;
        bus_ack = 1'b1;
        bus_rdata = 32'hCAFE_F00D;
        tick();
        bus_ack = 1'b0;
        #1;
        nchk++; if (mem_din !== 32'h1234_5678) $display("FAIL sim_din got=%h exp=12345678", mem_din); else npass++;
        nchk++; if (mem_stall !== 1'b0) $display("FAIL sim_stall got=%b exp=0", mem_stall); else npass++;
        mem_ren = 1'b0;
        mem_wen = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        mem_ren = 1'b1;
        mem_addr = 32'h0000_0010;
        tick();
        bus_ack = 1'b1;
        bus_rdata = 32'hAAAA_0001;
        tick();
        bus_ack = 1'b0;
        mem_addr = 32'h0000_0020;
        #1;
        nchk++; if (mem_din !== 32'hAAAA_0001) $display("FAIL b2b_din1 got=%h exp=aaaa0001", mem_din); else npass++;
        nchk++; if (mem_stall !== 1'b0) $display("FAIL b2b_stall_done got=%b exp=0", mem_stall); else npass++;
        tick();
        nchk++; if (bus_req !== 1'b0) $display("FAIL b2b_idle_req got=%b exp=0", bus_req); else npass++;
        nchk++; if (mem_stall !== 1'b1) $display("FAIL b2b_idle_stall got=%b exp=1", mem_stall); else npass++;
        tick();
        nchk++; if (bus_req !== 1'b1) $display("FAIL b2b_req2 got=%b exp=1", bus_req); else npass++;
        nchk++; if (bus_addr !== 32'h20) $display("FAIL b2b_addr2 got=%h exp=20", bus_addr); else npass++;
        bus_ack = 1'b1;
        bus_rdata = 32'hBBBB_0002;
        tick();
        bus_ack = 1'b0;
        mem_ren = 1'b0;
        #1;
        nchk++; if (mem_din !== 32'hBBBB_0002) $display("FAIL b2b_din2 got=%h exp=bbbb0002", mem_din); else npass++;
        tick();
    endtask

    task automatic test_timeout();
        mem_ren = 1'b1;
        mem_addr = 32'h0000_0400;
        for (int i = 1; i <= 4; i++) begin
            tick();
            nchk++; if (bus_req !== 1'b1) $display("FAIL to_req c%0d got=%b exp=1", i, bus_req); else npass++;
            nchk++; if (bus_err !== 1'b0) $display("FAIL to_err_early c%0d got=%b exp=0", i, bus_err); else npass++;
        end
        tick();
        nchk++; if (bus_req !== 1'b0) $display("FAIL to_req_done got=%b exp=0", bus_req); else npass++;
        nchk++; if (mem_stall !== 1'b0) $display("FAIL to_stall_done got=%b exp=0", mem_stall); else npass++;
        nchk++; if (mem_din !== 32'hDEAD_BEEF) $display("FAIL to_din got=%h exp=deadbeef", mem_din); else npass++;
        nchk++; if (bus_err !== 1'b1) $display("FAIL to_err got=%b exp=1", bus_err); else npass++;
        mem_ren = 1'b0;
        tick();
        mem_ren = 1'b1;
        mem_addr = 32'h0000_0008;
        tick();
        bus_ack = 1'b1;
        bus_rdata = 32'h0000_0055;
        tick();
        bus_ack = 1'b0;
        mem_ren = 1'b0;
        #1;
        nchk++; if (mem_din !== 32'h0000_0055) $display("FAIL to_good_din got=%h exp=55", mem_din); else npass++;
        nchk++; if (bus_err !== 1'b1) $display("FAIL to_err_sticky got=%b exp=1", bus_err); else npass++;
        tick();
    endtask

    task automatic test_reset_mid();
        mem_ren = 1'b1;
        mem_addr = 32'h0000_0500;
        tick();
        tick();
        rst = 1'b0;
        #1;
        nchk++; if (mem_stall !== 1'b0) $display("FAIL rm_stall_forced got=%b exp=0", mem_stall); else npass++;
        tick();
        rst = 1'b1;
        mem_ren = 1'b0;
        bus_ack = 1'b1;
        bus_rdata = 32'h7777_7777;
        #1;
        nchk++; if (bus_req !== 1'b0) $display("FAIL rm_req got=%b exp=0", bus_req); else npass++;
        nchk++; if (bus_err !== 1'b0) $display("FAIL rm_err got=%b exp=0", bus_err); else npass++;
        nchk++; if (mem_din !== 32'h0) $display("FAIL rm_din got=%h exp=0", mem_din); else npass++;
        tick();
        bus_ack = 1'b0;
        #1;
        nchk++; if (bus_req !== 1'b0) $display("FAIL rm_late_req got=%b exp=0", bus_req); else npass++;
        nchk++; if (mem_din !== 32'h0) $display("FAIL rm_late_din got=%h exp=0", mem_din); else npass++;
        nchk++; if (mem_stall !== 1'b0) $display("FAIL rm_late_stall got=%b exp=0", mem_stall); else npass++;
        tick();
    endtask

`ifdef DMEM_WRITE_BUFFER_EN
    task automatic test_posted_write();
        mem_wen = 1'b1;
        mem_addr = 32'h0000_0600;
        mem_dout = 32'h0BAD_F00D;
        #1;
        nchk++; if (mem_stall !== 1'b0) $display("FAIL pw_post_stall got=%b exp=0", mem_stall); else npass++;
        tick();
        mem_wen = 1'b0;
        mem_ren = 1'b1;
        #1;
        nchk++; if (bus_we !== 1'b1) $display("FAIL pw_we got=%b exp=1", bus_we); else npass++;
        nchk++; if (mem_stall !== 1'b1) $display("FAIL pw_rd_stall got=%b exp=1", mem_stall); else npass++;
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        #1;
        nchk++; if (mem_stall !== 1'b1) $display("FAIL pw_done_stall got=%b exp=1", mem_stall); else npass++;
        tick();
        nchk++; if (mem_stall !== 1'b1) $display("FAIL pw_idle_stall got=%b exp=1", mem_stall); else npass++;
        tick();
        nchk++; if (bus_we !== 1'b0) $display("FAIL pw_rd_we got=%b exp=0", bus_we); else npass++;
        bus_ack = 1'b1;
        bus_rdata = 32'h0BAD_F00D;
        tick();
        bus_ack = 1'b0;
        mem_ren = 1'b0;
        #1;
        nchk++; if (mem_din !== 32'h0BAD_F00D) $display("FAIL pw_din got=%h exp=0badf00d", mem_din); else npass++;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write();
        test_simul();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
`ifdef DMEM_WRITE_BUFFER_EN
        test_posted_write();
`endif
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder end of the core's data-memory port. It accepts the core's `mem_ren`/`mem_wen` requests, holds the core with `mem_stall` while each request completes over a req/ack backing bus, and returns read data on `mem_din`. It sits between the pipeline's MEM stage and the data RAM or bus bridge, and replaces the zero-wait-state memory model.

## Interface
- `TIMEOUT_CYCLES`, default 255: number of cycles in REQ without `bus_ack` before the access is aborted (1..255).
- `ERR_DATA`, default 32'hDEAD_BEEF: value returned on `mem_din` for a read that timed out.
- `clk` in 1: the only clock. All logic updates on its rising edge.
- `rst` in 1: synchronous reset, active-low (0 = reset).
- `mem_ren` in 1: core read request.
- `mem_wen` in 1: core write request. Takes priority if asserted together with `mem_ren`.
- `mem_addr` in 32: byte address. Bits [1:0] are ignored and forced to 0 on the bus.
- `mem_dout` in 32: write data from the core.
- `mem_din` out 32: registered read data to the core.
- `mem_stall` out 1: core must hold the MEM stage and keep the request stable.
- `bus_req` out 1: backing-bus request.
- `bus_we` out 1: backing-bus write strobe.
- `bus_addr` out 32: word-aligned bus address.
- `bus_wdata` out 32: bus write data.
- `bus_rdata` in 32: bus read data, valid when `bus_ack` is 1.
- `bus_ack` in 1: one-cycle completion pulse from the bus.
- `bus_err` out 1: sticky timeout flag. Cleared only by reset.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - A request is present when `mem_ren | mem_wen`.
  - On a request, latch the address (bits [1:0] forced to 00), the write data and the direction; go to REQ.
  - Clear the timeout counter.
- REQ:
  - `bus_req` = 1. `bus_addr`, `bus_wdata` and `bus_we` stay constant for the whole state.
  - On `bus_ack`: for reads, capture `bus_rdata` into `mem_din`; go to DONE.
  - If the counter reaches `TIMEOUT_CYCLES` without ack: for reads, `mem_din` <= `ERR_DATA`; set `bus_err`; go to DONE.
- DONE:
  - `mem_stall` = 0 and `bus_req` = 0. The core consumes the result on this edge.
  - Go to IDLE unconditionally. The core's next request is accepted in IDLE and never re-served from DONE.
- `mem_stall` is combinational:
  - 1 in IDLE when a request is present.
  - 1 throughout REQ.
  - 0 in DONE and in IDLE with no request.
  - Forced to 0 while `rst` = 0.
- `bus_ack` is ignored outside REQ.
- Address and data change on the core side while stalled are ignored; the latched values are used.

## Timing
- Reset (`rst` = 0 at an edge):
  - State goes to IDLE.
  - `mem_din`, `bus_req`, `bus_we`, `bus_addr`, `bus_wdata` and `bus_err` all go to 0; the counter and write buffer are cleared.
  - Reset during REQ drops `bus_req` at that edge, abandoning the access.
- Read latency, with a request first seen at cycle T:
  - `bus_req` rises at T+1.
  - With ack at cycle A (A ≥ T+1), DONE is at A+1 and `mem_din` is valid from A+1.
  - Minimum: 2 stall cycles; the core advances at the end of T+2.
- Timeout: with no ack, DONE falls at T+1+`TIMEOUT_CYCLES`; `bus_err` rises on that same edge.
- Back-to-back requests: there is at least one IDLE cycle between DONE and the next REQ.

## Configuration
- `DMEM_WRITE_BUFFER_EN` defined: posted writes through a one-entry write buffer.
  - A write seen in IDLE with the buffer empty is latched into the buffer with `mem_stall` = 0 in that cycle. The buffer then drains via REQ/DONE without stalling.
  - Any request arriving while the buffer drains stalls until its DONE and is then served normally. Read-after-write ordering is therefore preserved.
  - A timeout on a drained write sets `bus_err` only.
- Undefined: writes follow the same stalled handshake as reads. No buffer logic is present.

## Test plan
- Read, ack with zero wait: `mem_ren`, `mem_addr` = 0x0000_0104, ack at T+1 with `bus_rdata` = 0x1234_5678 -> `bus_addr` = 0x104, stall high T..T+1, `mem_din` = 0x1234_5678 at T+2, stall low.
- Write with 3-cycle ack delay, macro off: `mem_wen`, addr 0x0000_0203, data 0xA5A5_0001 -> `bus_we` = 1, `bus_addr` = 0x200, `bus_wdata` = 0xA5A5_0001 stable for 3 cycles, stall released in DONE.
- Timeout: `TIMEOUT_CYCLES` = 4, read, no ack -> DONE at T+5, `mem_din` = 0xDEAD_BEEF, `bus_err` = 1, and it stays 1 across later good accesses.
- Reset mid-REQ: `rst` = 0 at T+2 of a pending read -> `bus_req` = 0, `bus_err` = 0, `mem_din` = 0 next cycle; a late `bus_ack` is ignored.
- Simultaneous `mem_ren` and `mem_wen` -> treated as a write (`bus_we` = 1).
- Macro on: write then read back-to-back -> write posts with zero stall; the read stalls until the write's ack, then returns the written value from the bus.
